wash_cycle_timer: RTL

WASH_CYCLE_TIMER -- requirements
Module: wash_cycle_timer

---
 rtl/wash_cycle_timer.sv | 124 ++++++++++++
 1 files changed

// File: rtl/wash_cycle_timer.sv
// -----------------------------------------------------------------------------
// wash_cycle_timer
//
// Phase timer for a washing-machine controller. A phase is loaded with a
// duration in clk cycles and then counted down to zero, at which point a
// one-cycle completion pulse is raised. The countdown can be held (pause),
// cancelled (abort) or restarted (a new load). A direction flag for the drum
// motor inverts every DIR_PERIOD counted cycles of the running phase.
//
// Parameters
//   DIR_PERIOD   counted cycles between motor-direction toggles (>= 1)
//
// Ports
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset
//   timer_start  load request; loads timer_value and starts a phase
//   timer_value  phase duration in clk cycles (0 is treated as 1)
//   pause        level-sensitive hold; freezes the countdown while high
//   abort        cancels the running phase without signalling completion
//   timer_done   registered one-cycle pulse on phase completion
//   busy         high while a phase is running or held
//   remaining    registered count of cycles left in the current phase
//   dir_toggle   registered motor-direction flag
// -----------------------------------------------------------------------------
module wash_cycle_timer #(
    parameter int unsigned DIR_PERIOD = 1048576
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        timer_start,
    input  logic [31:0] timer_value,
    input  logic        pause,
    input  logic        abort,
    output logic        timer_done,
    output logic        busy,
    output logic [31:0] remaining,
    output logic        dir_toggle
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Last direction-counter value before it wraps and flips dir_toggle.
    localparam logic [31:0] DIR_LAST = 32'(DIR_PERIOD - 1);

    state_t      state;
    logic [31:0] dir_cnt;

    // Input priority on every edge: abort, then load, then pause/resume,
    // then countdown. busy is registered alongside state so that it always
    // reflects RUN or HOLD without a decode after the flops.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: every register here is a plain control/status flop, so all of
        // them take the async reset; there is no storage array to leave out.
        if (!reset_n) begin
            state      <= IDLE;
            busy       <= 1'b0;
            remaining  <= '0;
            timer_done <= 1'b0;
            dir_toggle <= 1'b0;
            dir_cnt    <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every test below
            // sees the pre-edge value of remaining/dir_cnt and the later
            // assignment to timer_done overrides this default cleanly.
            timer_done <= 1'b0;

            if (abort) begin
                state      <= IDLE;
                busy       <= 1'b0;
                remaining  <= '0;
                dir_toggle <= 1'b0;
                dir_cnt    <= '0;
            end else if (timer_start) begin
                // A reload discards any phase in flight without a done pulse,
                // including one that would have completed on this edge.
                state      <= RUN;
                busy       <= 1'b1;
                remaining  <= (timer_value == '0) ? 32'd1 : timer_value;
                dir_toggle <= 1'b0;
                dir_cnt    <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        // pause/abort alone do nothing; remaining holds.
                    end
                    RUN: begin
                        if (pause) begin
                            // Entering HOLD costs the edge: no decrement.
                            state <= HOLD;
                        end else if (remaining != '0) begin
                            remaining <= remaining - 32'd1;
                            if (dir_cnt == DIR_LAST) begin
                                dir_cnt    <= '0;
                                dir_toggle <= ~dir_toggle;
                            end else begin
                                dir_cnt <= dir_cnt + 32'd1;
                            end
                            if (remaining == 32'd1) begin
                                timer_done <= 1'b1;
                                state      <= IDLE;
                                busy       <= 1'b0;
                            end
                        end
                    end
                    HOLD: begin
                        // Resuming also costs the edge: no decrement.
                        if (!pause) begin
                            state <= RUN;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
